// File: rtl/orion_fetch_queue.sv
// Instruction-fetch front end: pipelined I$ requests, in-order response queue, and
// flush/redirect with discard of in-flight responses.
module orion_fetch_queue #(
   parameter int unsigned      ADDRW      = 32,
   parameter int unsigned      XLEN       = 32,
   parameter int unsigned      DEPTH      = 4,
   parameter int unsigned      MAX_OUTSTD = 2,
   parameter logic [ADDRW-1:0] RESET_PC   = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [ADDRW-1:0] imem_addr_o,
   output logic             imem_valid_o,
   input  logic             imem_ready_i,
   input  logic [XLEN-1:0]  imem_rdata_i,
   input  logic             imem_resp_i,
   input  logic             redirect_i,
   input  logic [ADDRW-1:0] redirect_pc_i,
   output logic             inst_valid_o,
   output logic [XLEN-1:0]  inst_o,
   output logic [ADDRW-1:0] pc_o,
   input  logic             inst_ready_i
);

   localparam int unsigned CW = $clog2(MAX_OUTSTD + 1);
   localparam int unsigned QW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned FW = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;

   logic [ADDRW-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]    live_q, live_d, drop_q, drop_d;
   logic [QW-1:0]    count_q, count_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [FW-1:0]    frd_q, frd_d, fwr_q, fwr_d;

   logic [ADDRW-1:0] q_pc_q   [DEPTH];
   logic [XLEN-1:0]  q_inst_q [DEPTH];
   logic [ADDRW-1:0] f_pc_q   [MAX_OUTSTD];

   logic        accept, resp_live, resp_drop, pop;
   logic [31:0] inflight, reserved;

   function automatic logic [PW-1:0] q_inc(input logic [PW-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
      return (32'(p) == MAX_OUTSTD - 1) ? '0 : p + FW'(1);
   endfunction

   // Reserving a slot per live request means a response can always be written.
   assign inflight     = 32'(live_q) + 32'(drop_q);
   assign reserved     = 32'(count_q) + 32'(live_q);
   assign imem_valid_o = !rst_i && !redirect_i && (inflight < MAX_OUTSTD) && (reserved < DEPTH);
   assign imem_addr_o  = fetch_pc_q;
   assign accept       = imem_valid_o && imem_ready_i;
   assign resp_drop    = imem_resp_i && (drop_q != '0);
   assign resp_live    = imem_resp_i && (drop_q == '0) && (live_q != '0);
   assign inst_valid_o = (count_q != '0);
   assign pop          = inst_valid_o && inst_ready_i;
   assign inst_o       = q_inst_q[head_q];
   assign pc_o         = q_pc_q[head_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      live_d     = live_q;
      drop_d     = drop_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      frd_d      = frd_q;
      fwr_d      = fwr_q;
      if (redirect_i) begin
         // Every outstanding request becomes a discard, less any response landing now.
         fetch_pc_d = {redirect_pc_i[ADDRW-1:2], 2'b00};
         live_d     = '0;
         drop_d     = drop_q + live_q - CW'(resp_live || resp_drop);
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         frd_d      = '0;
         fwr_d      = '0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + ADDRW'(4);
            fwr_d      = f_inc(fwr_q);
         end
         if (resp_live) begin
            tail_d = q_inc(tail_q);
            frd_d  = f_inc(frd_q);
         end
         if (pop) head_d = q_inc(head_q);
         live_d  = live_q + CW'(accept) - CW'(resp_live);
         drop_d  = drop_q - CW'(resp_drop);
         count_d = count_q + QW'(resp_live) - QW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         live_q     <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         frd_q      <= '0;
         fwr_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         live_q     <= live_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         frd_q      <= frd_d;
         fwr_q      <= fwr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_pc_q[i]   <= '0;
            q_inst_q[i] <= '0;
         end
         for (int i = 0; i < int'(MAX_OUTSTD); i++) f_pc_q[i] <= '0;
      end else if (!redirect_i) begin
         if (accept) f_pc_q[fwr_q] <= fetch_pc_q;
         if (resp_live) begin
            q_pc_q[tail_q]   <= f_pc_q[frd_q];
            q_inst_q[tail_q] <= imem_rdata_i;
         end
      end
   end

   a_resp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
      imem_resp_i |-> (inflight != 0));

endmodule

// File: tb/tb_orion_fetch_queue.sv
// Randomised scoreboard bench for orion_fetch_queue: an epoch-tagged I$ model decides which
// responses must reach decode, and a monitor compares every consumed head against it.
module tb_orion_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] imem_addr_o;
   logic        imem_valid_o;
   logic        imem_ready_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        imem_resp_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        inst_ready_i = 1'b0;

   orion_fetch_queue #(
      .ADDRW      (32),
      .XLEN       (32),
      .DEPTH      (DEPTH),
      .MAX_OUTSTD (MAX_OUT),
      .RESET_PC   (RESET_PC)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_addr_o   (imem_addr_o),
      .imem_valid_o  (imem_valid_o),
      .imem_ready_i  (imem_ready_i),
      .imem_rdata_i  (imem_rdata_i),
      .imem_resp_i   (imem_resp_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .pc_o          (pc_o),
      .inst_ready_i  (inst_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
      int unsigned epoch;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   req_t        pending[$];
   ent_t        exp_q[$];
   req_t        cur;
   logic [31:0] model_pc = RESET_PC;
   int unsigned epoch = 0;
   int unsigned cyc = 0;
   int unsigned last_due = 0;
   int unsigned p_ready = 100, p_iready = 100, p_redir = 0;
   int unsigned lat_min = 1, lat_max = 1;
   int          checks = 0, failures = 0, pops = 0;
   bit          prev_valid = 0, prev_ready = 0;
   logic [31:0] prev_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: compares each consumed head with the oldest expected entry.
   always @(negedge clk_i) begin
      #1;
      if (!rst_i) begin
         chk("inst_valid", inst_valid_o, exp_q.size() != 0);
         if (inst_valid_o && inst_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 1'b1, 1'b0);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               chk("pc_o", pc_o, e.pc);
               chk("inst_o", inst_o, e.inst);
               pops++;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      redirect_i = 1'b0;
      imem_ready_i = 1'b0;
      imem_resp_i = 1'b0;
      inst_ready_i = 1'b0;
      pending.delete();
      exp_q.delete();
      model_pc = RESET_PC;
      last_due = 0;
      prev_valid = 0;
      @(negedge clk_i);
      #2;
      chk("rst_imem_valid", imem_valid_o, 1'b0);
      chk("rst_inst_valid", inst_valid_o, 1'b0);
      chk("rst_imem_addr", imem_addr_o, RESET_PC);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      pops = 0;
   endtask

   task automatic step(input bit redir, input logic [31:0] rpc);
      bit          resp_now;
      int unsigned occ_now, live_now, due;
      bit          exp_valid;
      @(negedge clk_i);
      occ_now = exp_q.size();
      rst_i = 1'b0;
      redirect_i = redir;
      redirect_pc_i = rpc;
      imem_ready_i = ($urandom_range(99) < p_ready);
      inst_ready_i = ($urandom_range(99) < p_iready);
      resp_now = 0;
      if (pending.size() > 0 && pending[0].due <= cyc) begin
         cur = pending.pop_front();
         resp_now = 1;
      end
      imem_resp_i = resp_now;
      imem_rdata_i = resp_now ? mem_word(cur.addr) : $urandom();
      #2;
      // Requests whose data will still be delivered occupy reserved queue slots.
      live_now = (resp_now && cur.epoch == epoch) ? 1 : 0;
      foreach (pending[i]) if (pending[i].epoch == epoch) live_now++;
      exp_valid = !redir && (pending.size() + (resp_now ? 1 : 0) < MAX_OUT)
                  && (occ_now + live_now < DEPTH);
      chk("imem_valid", imem_valid_o, exp_valid);
      if (prev_valid && !prev_ready && !redir) begin
         chk("req_held_valid", imem_valid_o, 1'b1);
         chk("req_held_addr", imem_addr_o, prev_addr);
      end
      if (imem_valid_o && imem_ready_i) begin
         chk("imem_addr", imem_addr_o, model_pc);
         due = cyc + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pending.push_back('{addr: model_pc, due: due, epoch: epoch});
         model_pc = model_pc + 32'd4;
      end
      if (resp_now && !redir && cur.epoch == epoch)
         exp_q.push_back('{pc: cur.addr, inst: mem_word(cur.addr)});
      if (redir) begin
         exp_q.delete();
         epoch++;
         model_pc = rpc;
      end
      prev_valid = imem_valid_o;
      prev_ready = imem_ready_i;
      prev_addr = imem_addr_o;
      cyc++;
   endtask

   initial begin
      // Streaming at full rate: first head two cycles after the first request.
      do_reset();
      for (int i = 0; i < 30; i++) step(0, '0);
      chk("stream_pops", pops, 28);
      // Redirect while a response lands and the head is consumed.
      step(1, 32'h0000_0400);
      for (int i = 0; i < 10; i++) step(0, '0);

      // Decode stall fills the queue and stops fetch.
      do_reset();
      p_iready = 0;
      for (int i = 0; i < 20; i++) step(0, '0);
      chk("full_no_issue", imem_valid_o, 1'b0);
      chk("full_head_valid", inst_valid_o, 1'b1);
      chk("full_head_pc", pc_o, 32'h0);
      p_iready = 100;
      for (int i = 0; i < 12; i++) step(0, '0);

      // Two requests in flight discarded by a redirect.
      do_reset();
      lat_min = 3;
      lat_max = 3;
      step(0, '0);
      step(0, '0);
      step(1, 32'h0000_0100);
      chk("redir_flush", inst_valid_o, 1'b0);
      for (int i = 0; i < 12; i++) step(0, '0);

      // Stalled request, then redirect during the wait.
      p_ready = 0;
      for (int i = 0; i < 3; i++) step(0, '0);
      step(1, 32'h0000_0200);
      step(0, '0);
      chk("redir_addr", imem_addr_o, 32'h0000_0200);
      chk("redir_valid", imem_valid_o, 1'b1);
      step(0, '0);
      p_ready = 100;
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 8; i++) step(0, '0);

      // Address wraps past the top of memory.
      step(1, 32'hFFFF_FFF8);
      for (int i = 0; i < 10; i++) step(0, '0);

      // Random traffic with redirects and one mid-run reset.
      p_ready = 70;
      p_iready = 60;
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         bit          r;
         logic [31:0] rpc;
         r = ($urandom_range(99) < 5);
         rpc = ($urandom_range(9) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
         step(r, rpc);
         if (i == 1500) do_reset();
      end
      for (int i = 0; i < 20; i++) step(0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
